ocx_tlx_framer_rsp_sched: RTL

//  Scheduler around the TLX framer response FIFO (8 x 59b, sync-reset, combinational read port).

---
 rtl/ocx_tlx_framer_pkg.sv | 10 +
 rtl/ocx_tlx_framer_rsp_sched_if.sv | 60 ++++++
 rtl/ocx_tlx_rr_arb.sv | 40 ++++
 rtl/ocx_tlx_framer_rsp_sched.sv | 100 ++++++++++
 4 files changed

// File: rtl/ocx_tlx_framer_pkg.sv
// Shared TLX framer constants: response entry width, response FIFO geometry
// and TL response credit counter width.
package ocx_tlx_framer_pkg;

  localparam int TLX_RSP_WIDTH  = 59;
  localparam int RSP_FIFO_DEPTH = 8;
  localparam int RSP_FIFO_AW    = 3;
  localparam int RSP_CREDIT_W   = 4;

endpackage

// File: rtl/ocx_tlx_framer_rsp_sched_if.sv
// Bundle between the response scheduler and its neighbours: response
// requesters, the framer response FIFO, the slot packer and TL credit logic.
interface ocx_tlx_framer_rsp_sched_if #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = ocx_tlx_framer_pkg::TLX_RSP_WIDTH,
  parameter int FIFO_ADDR_WIDTH = ocx_tlx_framer_pkg::RSP_FIFO_AW,
  parameter int CREDIT_WIDTH    = ocx_tlx_framer_pkg::RSP_CREDIT_W
);

  // requesters: slice i of req_data belongs to requester i
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ack;

  // response FIFO
  logic                       fifo_wr_enable;
  logic [DATA_WIDTH-1:0]      fifo_data_in;
  logic [FIFO_ADDR_WIDTH:0]   fifo_valid_entry_count;
  logic                       fifo_data_available;
  logic [DATA_WIDTH-1:0]      fifo_data_out;
  logic                       fifo_rd_done;

  // framer slot packer
  logic                       frm_rsp_valid;
  logic [DATA_WIDTH-1:0]      frm_rsp_data;
  logic                       frm_rsp_taken;

  // TL response credits and error pulses
  logic                       credit_return;
  logic                       credit_init_valid;
  logic [CREDIT_WIDTH-1:0]    credit_init_value;
  logic [CREDIT_WIDTH-1:0]    credit_count;
  logic                       credit_overflow_error;
  logic                       taken_error;

  modport master (
    input  req_valid, req_data,
    output req_ack,
    output fifo_wr_enable, fifo_data_in,
    input  fifo_valid_entry_count, fifo_data_available, fifo_data_out,
    output fifo_rd_done,
    output frm_rsp_valid, frm_rsp_data,
    input  frm_rsp_taken,
    input  credit_return, credit_init_valid, credit_init_value,
    output credit_count, credit_overflow_error, taken_error
  );

  modport slave (
    output req_valid, req_data,
    input  req_ack,
    input  fifo_wr_enable, fifo_data_in,
    output fifo_valid_entry_count, fifo_data_available, fifo_data_out,
    input  fifo_rd_done,
    input  frm_rsp_valid, frm_rsp_data,
    output frm_rsp_taken,
    output credit_return, credit_init_valid, credit_init_value,
    input  credit_count, credit_overflow_error, taken_error
  );

endinterface

// File: rtl/ocx_tlx_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester above the last
// winner; the pointer moves only when a grant is issued.
module ocx_tlx_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (enable && req[cand[PW-1:0]]) begin
        gnt                 = '0;
        gnt[cand[PW-1:0]]   = 1'b1;
        gnt_idx             = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  ptr <= PW'(NUM_REQ-1);
    else if (|gnt) ptr <= gnt_idx;
  end

endmodule

// File: rtl/ocx_tlx_framer_rsp_sched.sv
// TLX framer response scheduler: arbitrates requesters into the response FIFO
// without overflow and offers the FIFO head to the framer while credits last.
module ocx_tlx_framer_rsp_sched #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = ocx_tlx_framer_pkg::TLX_RSP_WIDTH,
  parameter int FIFO_ADDR_WIDTH = ocx_tlx_framer_pkg::RSP_FIFO_AW,
  parameter int FIFO_DEPTH      = ocx_tlx_framer_pkg::RSP_FIFO_DEPTH,
  parameter int CREDIT_WIDTH    = ocx_tlx_framer_pkg::RSP_CREDIT_W
) (
  input logic                         clock,
  input logic                         reset_n,
  ocx_tlx_framer_rsp_sched_if.master  bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = {CREDIT_WIDTH{1'b1}};

  logic [NUM_REQ-1:0]        gnt;
  logic [PW-1:0]             gnt_idx;
  logic [FIFO_ADDR_WIDTH+1:0] occ_nxt;
  logic                      space_ok;

  logic                      wr_en_q;
  logic [DATA_WIDTH-1:0]     wr_data_q;

  logic                      rsp_vld;
  logic                      consume;
  logic [CREDIT_WIDTH-1:0]   credit_q, credit_d;
  logic                      ovf_d, ovf_q;
  logic                      taken_err_d, taken_err_q;

  // Count the in-flight write as occupied and ignore same-cycle pops; this
  // keeps the FIFO from ever seeing a write while full.
  assign occ_nxt  = {1'b0, bus.fifo_valid_entry_count}
                  + {{(FIFO_ADDR_WIDTH+1){1'b0}}, wr_en_q};
  assign space_ok = occ_nxt < (FIFO_ADDR_WIDTH+2)'(FIFO_DEPTH);

  ocx_tlx_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .enable  (space_ok & reset_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ack = gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= |gnt;
      if (|gnt) wr_data_q <= bus.req_data[gnt_idx];
    end
  end

  assign bus.fifo_wr_enable = wr_en_q;
  assign bus.fifo_data_in   = wr_data_q;

  // Credit reload masks the head for its cycle so the load value is exact.
  assign rsp_vld = bus.fifo_data_available & (credit_q != '0) & ~bus.credit_init_valid;
  assign consume = rsp_vld & bus.frm_rsp_taken & reset_n;

  assign bus.frm_rsp_valid = rsp_vld;
  assign bus.frm_rsp_data  = bus.fifo_data_out;
  assign bus.fifo_rd_done  = consume;

  always_comb begin
    credit_d    = credit_q;
    ovf_d       = 1'b0;
    taken_err_d = bus.frm_rsp_taken & ~rsp_vld;
    if (bus.credit_init_valid) begin
      credit_d = bus.credit_init_value;
    end else if (consume && !bus.credit_return) begin
      credit_d = credit_q - CREDIT_WIDTH'(1);
    end else if (bus.credit_return && !consume) begin
      if (credit_q == CRED_MAX) ovf_d    = 1'b1;
      else                      credit_d = credit_q + CREDIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_q    <= '0;
      ovf_q       <= 1'b0;
      taken_err_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      ovf_q       <= ovf_d;
      taken_err_q <= taken_err_d;
    end
  end

  assign bus.credit_count          = credit_q;
  assign bus.credit_overflow_error = ovf_q;
  assign bus.taken_error           = taken_err_q;

endmodule
